sha256_msg_schedule: RTL and testbench

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha256_pkg.sv | 42 ++++
 rtl/sha256_k_rom.sv | 10 +
 rtl/sha256_msg_schedule.sv | 162 ++++++++++++++++
 tb/tb_sha256_msg_schedule.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, schedule sizes, FSM states and sigma functions.
package sha256_pkg;

  localparam int ROUNDS = 64;
  localparam int WORDS  = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Index 0 is the leftmost element of the packed table.
  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup.
module sha256_k_rom (
  input  logic [5:0]  idx,
  output logic [31:0] k
);
  import sha256_pkg::*;

  assign k = K_TABLE[idx];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 16-word chunk, streams W_t/K_t for 64 rounds, then FINAL and GAP.
// Optional: define SHA256_MSG_BSWAP_EN to byte-reverse each incoming word for little-endian sources.
module sha256_msg_schedule #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic        enable,
  output logic        update,
  output logic [31:0] w_out,
  output logic [31:0] k_out,
  output logic        chunk_done,
  output logic        msg_done
);
  import sha256_pkg::*;

  localparam logic [3:0] LAST_WORD  = 4'(WORDS - 1);
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
  localparam logic [3:0] LAST_GAP   = 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [5:0]  t;
  logic [3:0]  gap_cnt;
  logic        last_q;
  logic        ready_q;
  logic        enable_q;
  logic        update_q;
  logic        chunk_q;
  logic        msg_q;
  logic [31:0] msg_buf [0:15];
  logic [31:0] in_word;
  logic [31:0] sched_word;
  logic [31:0] round_word;
  logic [31:0] k_val;
  logic [3:0]  t4;
  logic        accept;

`ifdef SHA256_MSG_BSWAP_EN
  assign in_word = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
  assign in_word = s_data;
`endif

  assign t4      = t[3:0];
  assign s_ready = ready_q & ~rst;
  assign accept  = s_valid & s_ready;

  // The 16-entry ring holds W_{t-16..t-1}; 4-bit index arithmetic gives the mod-16 wrap.
  always_comb begin
    sched_word = sig1(msg_buf[t4 - 4'd2]) + msg_buf[t4 - 4'd7]
               + sig0(msg_buf[t4 - 4'd15]) + msg_buf[t4];
    if (t[5:4] == 2'b00) begin
      round_word = msg_buf[t4];
    end else begin
      round_word = sched_word;
    end
  end

  sha256_k_rom u_k_rom (
    .idx (t),
    .k   (k_val)
  );

  always_comb begin
    w_out = 32'h0000_0000;
    k_out = 32'h0000_0000;
    case (state)
      ST_ROUND: begin
        w_out = round_word;
        k_out = k_val;
      end
      default: begin
        w_out = 32'h0000_0000;
        k_out = 32'h0000_0000;
      end
    endcase
  end

  // Buffer needs no reset: a chunk is always fully reloaded before it is read.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && accept) begin
      msg_buf[cnt] <= in_word;
    end else if (state == ST_ROUND) begin
      msg_buf[t4] <= round_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOAD;
      cnt      <= 4'd0;
      t        <= 6'd0;
      gap_cnt  <= 4'd0;
      last_q   <= 1'b0;
      ready_q  <= 1'b1;
      enable_q <= 1'b0;
      update_q <= 1'b0;
      chunk_q  <= 1'b0;
      msg_q    <= 1'b0;
    end else begin
      chunk_q <= 1'b0;
      msg_q   <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_WORD) begin
              last_q   <= s_last;
              state    <= ST_ROUND;
              t        <= 6'd0;
              ready_q  <= 1'b0;
              enable_q <= 1'b1;
            end
          end
        end
        ST_ROUND: begin
          t <= t + 6'd1;
          if (t == LAST_ROUND) begin
            state    <= ST_FINAL;
            update_q <= 1'b1;
          end
        end
        ST_FINAL: begin
          state    <= ST_GAP;
          enable_q <= 1'b0;
          update_q <= 1'b0;
          chunk_q  <= 1'b1;
          msg_q    <= last_q;
          gap_cnt  <= 4'd0;
        end
        ST_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state   <= ST_LOAD;
            cnt     <= 4'd0;
            ready_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state    <= ST_LOAD;
          cnt      <= 4'd0;
          ready_q  <= 1'b1;
          enable_q <= 1'b0;
          update_q <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are forced low for the whole reset cycle, so a reset landing on FINAL never leaks an update.
  assign enable     = enable_q & ~rst;
  assign update     = update_q & ~rst;
  assign chunk_done = chunk_q & ~rst;
  assign msg_done   = msg_q & ~rst;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed self-checking bench for sha256_msg_schedule ("abc" schedule, stalls, back-to-back, reset, s_last).
module tb_sha256_msg_schedule;

  localparam int G = 1;

`ifdef SHA256_MSG_BSWAP_EN
  localparam logic [31:0] ABC_W0_IN = 32'h80636261;
`else
  localparam logic [31:0] ABC_W0_IN = 32'h61626380;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic        enable;
  logic        update;
  logic [31:0] w_out;
  logic [31:0] k_out;
  logic        chunk_done;
  logic        msg_done;

  int errors = 0;
  int checks = 0;
  int cyc_load;
  int accepted;
  int n_obs;
  int total_cd = 0;
  int total_md = 0;

  logic [31:0] words [16];
  logic        lastv [16];
  logic [31:0] w_log [200];
  logic [31:0] k_log [200];
  logic        en_log [200];
  logic        up_log [200];
  logic        cd_log [200];
  logic        md_log [200];

  always #5 clk = ~clk;

  sha256_msg_schedule #(.GAP_CYCLES(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_last     (s_last),
    .enable     (enable),
    .update     (update),
    .w_out      (w_out),
    .k_out      (k_out),
    .chunk_done (chunk_done),
    .msg_done   (msg_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      words[i] = base + 32'(i);
      lastv[i] = 1'b0;
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) begin
      words[i] = 32'h0000_0000;
      lastv[i] = 1'b0;
    end
    words[0]  = ABC_W0_IN;
    words[15] = 32'h0000_0018;
    lastv[15] = 1'b1;
  endtask

  task automatic load_chunk(input bit toggle);
    logic go;
    accepted = 0;
    cyc_load = 0;
    while (accepted < 16 && cyc_load < 100) begin
      s_valid = toggle ? (cyc_load % 2 == 0) : 1'b1;
      s_data  = words[accepted];
      s_last  = lastv[accepted];
      go      = s_valid & s_ready;
      step();
      cyc_load++;
      if (go) accepted++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'hdead_beef;
  endtask

  task automatic observe();
    n_obs = 0;
    while (s_ready !== 1'b1 && n_obs < 200) begin
      w_log[n_obs]  = w_out;
      k_log[n_obs]  = k_out;
      en_log[n_obs] = enable;
      up_log[n_obs] = update;
      cd_log[n_obs] = chunk_done;
      md_log[n_obs] = msg_done;
      if (chunk_done === 1'b1) total_cd++;
      if (msg_done === 1'b1) total_md++;
      step();
      n_obs++;
    end
  endtask

  task automatic check_chunk(input string name, input logic exp_msg);
    int bad;
    int cd;
    int md;
    bad = 0;
    cd = 0;
    md = 0;
    chk({name, "_accepted"}, 32'(accepted), 32'd16);
    chk({name, "_busy_cycles"}, 32'(n_obs), 32'(65 + G));
    chk({name, "_first_enable"}, {31'd0, en_log[0]}, 32'd1);
    for (int i = 0; i < 64; i++) begin
      if (en_log[i] !== 1'b1 || up_log[i] !== 1'b0) bad++;
    end
    chk({name, "_round_strobes_bad"}, 32'(bad), 32'd0);
    chk({name, "_final_enable"}, {31'd0, en_log[64]}, 32'd1);
    chk({name, "_final_update"}, {31'd0, up_log[64]}, 32'd1);
    chk({name, "_final_w"}, w_log[64], 32'h0000_0000);
    chk({name, "_final_k"}, k_log[64], 32'h0000_0000);
    chk({name, "_gap_enable"}, {31'd0, en_log[65]}, 32'd0);
    chk({name, "_gap_chunk_done"}, {31'd0, cd_log[65]}, 32'd1);
    chk({name, "_gap_msg_done"}, {31'd0, md_log[65]}, {31'd0, exp_msg});
    for (int i = 0; i < n_obs; i++) begin
      if (cd_log[i] === 1'b1) cd++;
      if (md_log[i] === 1'b1) md++;
    end
    chk({name, "_chunk_done_pulses"}, 32'(cd), 32'd1);
    chk({name, "_msg_done_pulses"}, 32'(md), {31'd0, exp_msg});
  endtask

  initial begin
    int upd_seen;
    int en_seen;
    int rdy_low;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 32'h0000_0000;
    s_last  = 1'b0;
    repeat (3) step();
    chk("rst_enable", {31'd0, enable}, 32'd0);
    chk("rst_update", {31'd0, update}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_chunk_done", {31'd0, chunk_done}, 32'd0);
    chk("rst_msg_done", {31'd0, msg_done}, 32'd0);

    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    step();
    chk("idle_s_ready", {31'd0, s_ready}, 32'd1);
    chk("idle_enable", {31'd0, enable}, 32'd0);

    // "abc" single-chunk message
    set_abc();
    load_chunk(1'b0);
    chk("abc_load_cycles", 32'(cyc_load), 32'd16);
    observe();
    check_chunk("abc", 1'b1);
    chk("abc_W0", w_log[0], 32'h6162_6380);
    chk("abc_W15", w_log[15], 32'h0000_0018);
    chk("abc_W16", w_log[16], 32'h6162_6380);
    chk("abc_W17", w_log[17], 32'h000F_0000);
    chk("abc_W19", w_log[19], 32'h6000_03C6);
    chk("abc_K0", k_log[0], 32'h428a_2f98);
    chk("abc_K1", k_log[1], 32'h7137_4491);
    chk("abc_K63", k_log[63], 32'hc671_78f2);

    // s_valid toggling: 16 beats over 31 cycles
    set_words(32'hA000_0000);
    load_chunk(1'b1);
    chk("tog_load_cycles", 32'(cyc_load), 32'd31);
    observe();
    check_chunk("tog", 1'b0);
    chk("tog_W0", w_log[0], 32'hA000_0000);
    chk("tog_W15", w_log[15], 32'hA000_000F);

    // Back-to-back chunks, s_last only on the second
    total_cd = 0;
    total_md = 0;
    set_words(32'hB000_0000);
    load_chunk(1'b0);
    observe();
    check_chunk("b2b1", 1'b0);
    set_words(32'hC000_0000);
    lastv[15] = 1'b1;
    load_chunk(1'b0);
    chk("b2b2_load_cycles", 32'(cyc_load), 32'd16);
    observe();
    check_chunk("b2b2", 1'b1);
    chk("b2b_W0_second", w_log[0], 32'hC000_0000);
    chk("b2b_total_chunk_done", 32'(total_cd), 32'd2);
    chk("b2b_total_msg_done", 32'(total_md), 32'd1);

    // s_last on word 7 only
    set_words(32'hD000_0000);
    lastv[7] = 1'b1;
    load_chunk(1'b0);
    observe();
    check_chunk("w7", 1'b0);

    // Reset during round t=30
    set_words(32'hE000_0000);
    load_chunk(1'b0);
    repeat (30) step();
    chk("mid_round_enable", {31'd0, enable}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst30_enable", {31'd0, enable}, 32'd0);
    chk("rst30_update", {31'd0, update}, 32'd0);
    chk("rst30_s_ready", {31'd0, s_ready}, 32'd1);
    upd_seen = 0;
    en_seen = 0;
    rdy_low = 0;
    for (int i = 0; i < 80; i++) begin
      if (update !== 1'b0) upd_seen++;
      if (enable !== 1'b0) en_seen++;
      if (s_ready !== 1'b1) rdy_low++;
      step();
    end
    chk("rst30_no_update", 32'(upd_seen), 32'd0);
    chk("rst30_no_enable", 32'(en_seen), 32'd0);
    chk("rst30_ready_held", 32'(rdy_low), 32'd0);
    set_abc();
    load_chunk(1'b0);
    chk("rst30_reload_cycles", 32'(cyc_load), 32'd16);
    observe();
    check_chunk("reabc", 1'b1);
    chk("reabc_W0", w_log[0], 32'h6162_6380);
    chk("reabc_W17", w_log[17], 32'h000F_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
